// File: rtl/lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : lsu_ctrl
//  Purpose  : Memory-stage load/store unit: valid/ack bus master with byte
//             enables, load extension, misalignment and timeout detection.
//  Revision : 1.0  initial release
// ============================================================================
module lsu_ctrl #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_req_valid,
    output logic                    o_req_ready,
    input  logic                    i_req_we,
    input  logic [1:0]              i_req_size,
    input  logic                    i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0]   i_req_addr,
    input  logic [DATA_WIDTH-1:0]   i_req_wdata,
    input  logic [4:0]              i_req_rd,
    output logic                    o_rsp_valid,
    output logic [DATA_WIDTH-1:0]   o_rsp_rdata,
    output logic [4:0]              o_rsp_rd,
    output logic                    o_rsp_err,
    output logic                    o_bus_req,
    output logic                    o_bus_we,
    output logic [ADDR_WIDTH-1:0]   o_bus_addr,
    output logic [DATA_WIDTH-1:0]   o_bus_wdata,
    output logic [DATA_WIDTH/8-1:0] o_bus_be,
    input  logic                    i_bus_ack,
    input  logic [DATA_WIDTH-1:0]   i_bus_rdata
);

    localparam int c_BEW   = DATA_WIDTH / 8;
    localparam int c_L     = $clog2(c_BEW);
    localparam int c_CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX =
        c_CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam bit   c_HAS_DW = (DATA_WIDTH == 64);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic                    r_we;
    logic                    r_uns;
    logic [1:0]              r_size;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [DATA_WIDTH-1:0]   r_wdata;
    logic [4:0]              r_rd;
    logic [DATA_WIDTH-1:0]   r_rsp_rdata;
    logic                    r_rsp_err;
    logic [c_CNT_W-1:0]      r_cnt;

    logic                    w_req_bad;
    logic                    w_in_bus;
    logic                    w_in_resp;
    logic                    w_ack;
    logic                    w_timeout;
    logic [c_L-1:0]          w_off;
    logic [c_BEW-1:0]        w_be;
    logic [DATA_WIDTH-1:0]   w_bus_wdata;
    logic [DATA_WIDTH-1:0]   w_shifted;
    logic [DATA_WIDTH-1:0]   w_top;
    logic [DATA_WIDTH-1:0]   w_load;
    logic [6:0]              w_pad;

    always_comb begin
        w_req_bad = 1'b0;
        case (i_req_size)
            2'd1:    w_req_bad = i_req_addr[0];
            2'd2:    w_req_bad = |i_req_addr[1:0];
            2'd3:    w_req_bad = !c_HAS_DW || (|i_req_addr[2:0]);
            default: w_req_bad = 1'b0;
        endcase
    end

    assign w_in_bus  = (r_state == ST_BUS);
    assign w_in_resp = (r_state == ST_RESP);
    assign w_ack     = w_in_bus && i_bus_ack;
    assign w_timeout = (TIMEOUT_CYCLES != 0) && w_in_bus && !i_bus_ack && (r_cnt == c_CNT_MAX);
    assign w_off     = r_addr[c_L-1:0];

    always_comb begin
        w_be        = '1;
        w_bus_wdata = r_wdata;
        w_pad       = 7'd0;
        case (r_size)
            2'd0: begin
                w_be        = c_BEW'(1) << w_off;
                w_bus_wdata = {c_BEW{r_wdata[7:0]}};
                w_pad       = 7'(DATA_WIDTH - 8);
            end
            2'd1: begin
                w_be        = c_BEW'(3) << w_off;
                w_bus_wdata = {(c_BEW/2){r_wdata[15:0]}};
                w_pad       = 7'(DATA_WIDTH - 16);
            end
            2'd2: begin
                w_be        = c_BEW'(15) << w_off;
                w_bus_wdata = {(c_BEW/4){r_wdata[31:0]}};
                w_pad       = 7'(DATA_WIDTH - 32);
            end
            default: begin
                w_be        = '1;
                w_bus_wdata = r_wdata;
                w_pad       = 7'd0;
            end
        endcase
    end

    // Park the selected field at the MSB, then shift back down to extend.
    always_comb begin
        w_shifted = i_bus_rdata >> {w_off, 3'b000};
        w_top     = w_shifted << w_pad;
        if (r_uns) begin
            w_load = w_top >> w_pad;
        end else begin
            w_load = $signed(w_top) >>> w_pad;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (i_req_valid) w_state_nxt = w_req_bad ? ST_RESP : ST_BUS;
            ST_BUS:  if (w_ack || w_timeout) w_state_nxt = ST_RESP;
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_uns       <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_rd        <= 5'd0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (i_req_valid) begin
                        r_we        <= i_req_we;
                        r_uns       <= i_req_unsigned;
                        r_size      <= i_req_size;
                        r_addr      <= i_req_addr;
                        r_wdata     <= i_req_wdata;
                        r_rd        <= i_req_rd;
                        r_rsp_rdata <= '0;
                        r_rsp_err   <= w_req_bad;
                        r_cnt       <= '0;
                    end
                end
                ST_BUS: begin
                    if (w_ack) begin
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_load;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        if (w_timeout) begin
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready = (r_state == ST_IDLE);
    assign o_bus_req   = w_in_bus;
    assign o_bus_we    = w_in_bus && r_we;
    assign o_bus_addr  = w_in_bus ? {r_addr[ADDR_WIDTH-1:c_L], {c_L{1'b0}}} : '0;
    assign o_bus_be    = w_in_bus ? w_be : '0;
    assign o_bus_wdata = w_in_bus ? w_bus_wdata : '0;
    assign o_rsp_valid = w_in_resp;
    assign o_rsp_rdata = w_in_resp ? r_rsp_rdata : '0;
    assign o_rsp_rd    = w_in_resp ? r_rd : 5'd0;
    assign o_rsp_err   = w_in_resp && r_rsp_err;

endmodule
`default_nettype wire

// File: tb/tb_lsu_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_lsu_ctrl
//  Purpose  : Self-checking bench for lsu_ctrl (32-bit with short timeout,
//             plus a 64-bit instance for doubleword accesses).
//  Revision : 1.0  initial release
// ============================================================================
module tb_lsu_ctrl;

    localparam int T = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        req_valid, req_we, req_uns, bus_ack;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, bus_rdata;
    logic [4:0]  req_rd;
    logic        req_ready, rsp_valid, rsp_err, bus_req, bus_we;
    logic [31:0] rsp_rdata, bus_addr, bus_wdata;
    logic [4:0]  rsp_rd;
    logic [3:0]  bus_be;

    logic        d_valid, d_we, d_uns, d_ack;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [63:0] d_wdata, d_rdata;
    logic [4:0]  d_rd;
    logic        d_ready, d_rsp_valid, d_rsp_err, d_bus_req, d_bus_we;
    logic [63:0] d_rsp_rdata, d_bus_wdata;
    logic [31:0] d_bus_addr;
    logic [4:0]  d_rsp_rd;
    logic [7:0]  d_bus_be;

    lsu_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
        .i_req_size(req_size), .i_req_unsigned(req_uns), .i_req_addr(req_addr),
        .i_req_wdata(req_wdata), .i_req_rd(req_rd),
        .o_rsp_valid(rsp_valid), .o_rsp_rdata(rsp_rdata), .o_rsp_rd(rsp_rd), .o_rsp_err(rsp_err),
        .o_bus_req(bus_req), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
        .i_bus_ack(bus_ack), .i_bus_rdata(bus_rdata)
    );

    lsu_ctrl #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(16)) dut64 (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req_valid(d_valid), .o_req_ready(d_ready), .i_req_we(d_we),
        .i_req_size(d_size), .i_req_unsigned(d_uns), .i_req_addr(d_addr),
        .i_req_wdata(d_wdata), .i_req_rd(d_rd),
        .o_rsp_valid(d_rsp_valid), .o_rsp_rdata(d_rsp_rdata), .o_rsp_rd(d_rsp_rd), .o_rsp_err(d_rsp_err),
        .o_bus_req(d_bus_req), .o_bus_we(d_bus_we), .o_bus_addr(d_bus_addr),
        .o_bus_wdata(d_bus_wdata), .o_bus_be(d_bus_be),
        .i_bus_ack(d_ack), .i_bus_rdata(d_rdata)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  rd;
        int          ack_at;   // BUS cycle index carrying the ack; <0 never
        logic        bus;
        logic [3:0]  be;
        logic [31:0] bwdata;
        logic [31:0] rsp;
        logic        err;
    } vec_t;

    // Reference model: bytes = 2^size, legality by modulo, extension by arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t            e;
        int              nb;
        int              off;
        longint unsigned val;
        e = v;
        nb = 1 << v.size;
        off = int'(v.addr % 4);
        e.bus = 1'b0; e.be = 4'd0; e.bwdata = 32'd0; e.rsp = 32'd0; e.err = 1'b0;
        if (nb > 4 || (v.addr % nb) != 0) begin
            e.err = 1'b1;
            return e;
        end
        e.bus = 1'b1;
        e.be  = 4'(((1 << nb) - 1) << off);
        for (int i = 0; i < 4; i++) e.bwdata[8*i +: 8] = v.wdata[8*(i % nb) +: 8];
        if (v.ack_at < 0 || v.ack_at >= T) begin
            e.err = 1'b1;
        end else if (!v.we) begin
            val = (longint'(v.rdata) >> (8 * off)) & ((64'd1 << (8 * nb)) - 1);
            if (!v.uns && nb < 4 && val[8*nb-1]) val = val - (64'd1 << (8 * nb));
            e.rsp = 32'(val);
        end
        return e;
    endfunction

    task automatic txn(input vec_t v);
        int c;
        c = 0;
        @(negedge clk);
        chk("idle_ready", req_ready, 1);
        chk("idle_rsp_valid", rsp_valid, 0);
        req_valid = 1'b1; req_we = v.we; req_size = v.size; req_uns = v.uns;
        req_addr = v.addr; req_wdata = v.wdata; req_rd = v.rd;
        @(negedge clk);
        req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
        req_uns = 1'($urandom); req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
        if (!v.bus) begin
            chk("err_no_bus_req", bus_req, 0);
        end else begin
            forever begin
                chk("bus_req", bus_req, 1);
                chk("bus_addr", bus_addr, v.addr & ~32'h3);
                chk("bus_be", bus_be, v.be);
                chk("bus_we", bus_we, v.we);
                if (v.we) chk("bus_wdata", bus_wdata, v.bwdata);
                chk("busy_ready", req_ready, 0);
                chk("busy_rsp_valid", rsp_valid, 0);
                if (c == v.ack_at) begin
                    bus_ack = 1'b1; bus_rdata = v.rdata;
                end else begin
                    bus_ack = 1'b0; bus_rdata = $urandom;
                end
                @(negedge clk);
                bus_ack = 1'b0;
                c++;
                if (c - 1 == v.ack_at || c == T) break;
            end
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_rdata", rsp_rdata, v.rsp);
        chk("rsp_rd", rsp_rd, v.rd);
        chk("rsp_err", rsp_err, v.err);
        chk("rsp_bus_req", bus_req, 0);
        chk("rsp_ready", req_ready, 0);
    endtask

    task automatic txn64(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                         input logic [7:0] exp_be, input logic [63:0] exp_wdata, input logic [63:0] exp_rsp);
        @(negedge clk);
        chk("d_ready", d_ready, 1);
        d_valid = 1'b1; d_we = we; d_size = size; d_uns = uns; d_addr = addr; d_wdata = wdata; d_rd = 5'd30;
        @(negedge clk);
        d_valid = 1'b0;
        chk("d_bus_req", d_bus_req, 1);
        chk("d_bus_be", d_bus_be, exp_be);
        chk("d_bus_addr", d_bus_addr, addr & ~32'h7);
        if (we) chk("d_bus_wdata", d_bus_wdata, exp_wdata);
        d_ack = 1'b1; d_rdata = rdata;
        @(negedge clk);
        d_ack = 1'b0;
        chk("d_rsp_valid", d_rsp_valid, 1);
        chk("d_rsp_rdata", d_rsp_rdata, exp_rsp);
        chk("d_rsp_rd", d_rsp_rd, 30);
        chk("d_rsp_err", d_rsp_err, 0);
    endtask

    task automatic back_to_back();
        int q[$];
        int prev;
        int nresp;
        prev = -1; nresp = 0;
        req_we = 1'b0; req_size = 2'd2; req_uns = 1'b0; req_addr = 32'h100;
        bus_ack = 1'b1; bus_rdata = 32'h11223344;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk);
            if (rsp_valid) begin
                nresp++;
                chk("b2b_rsp_rd", rsp_rd, (q.size() > 0) ? 5'(q.pop_front()) : 5'h1F);
                chk("b2b_rsp_rdata", rsp_rdata, 32'h11223344);
            end
            if (cyc < 18) begin
                req_valid = 1'b1;
                req_rd = 5'(cyc);
                if (req_ready) begin
                    q.push_back(cyc);
                    if (prev >= 0) chk("b2b_spacing", cyc - prev, 3);
                    prev = cyc;
                end
            end else begin
                req_valid = 1'b0;
            end
        end
        bus_ack = 1'b0;
        chk("b2b_resp_count", nresp, 6);
        chk("b2b_queue_empty", q.size(), 0);
    endtask

    vec_t tbl[14];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        tbl[0]  = '{1'b0, 2'd0, 1'b0, 32'h1003, 32'h0,        32'h80123456, 5'd3,  1,  1'b1, 4'b1000, 32'h0,        32'hFFFFFF80, 1'b0};
        tbl[1]  = '{1'b0, 2'd1, 1'b1, 32'h2002, 32'h0,        32'hBEEF1234, 5'd7,  0,  1'b1, 4'b1100, 32'h0,        32'h0000BEEF, 1'b0};
        tbl[2]  = '{1'b1, 2'd0, 1'b0, 32'h3001, 32'h000000A5, 32'h0,        5'd9,  2,  1'b1, 4'b0010, 32'hA5A5A5A5, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 2'd2, 1'b0, 32'h4002, 32'h0,        32'h0,        5'd11, 0,  1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[4]  = '{1'b0, 2'd3, 1'b0, 32'h5000, 32'h0,        32'h12345678, 5'd12, 0,  1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[5]  = '{1'b0, 2'd1, 1'b0, 32'h6002, 32'h0,        32'h80017777, 5'd13, 0,  1'b1, 4'b1100, 32'h0,        32'hFFFF8001, 1'b0};
        tbl[6]  = '{1'b0, 2'd2, 1'b1, 32'h7004, 32'h0,        32'hDEADBEEF, 5'd14, 1,  1'b1, 4'b1111, 32'h0,        32'hDEADBEEF, 1'b0};
        tbl[7]  = '{1'b1, 2'd1, 1'b0, 32'h8002, 32'h1234ABCD, 32'h0,        5'd15, 0,  1'b1, 4'b1100, 32'hABCDABCD, 32'h0,        1'b0};
        tbl[8]  = '{1'b1, 2'd2, 1'b0, 32'h9000, 32'hCAFEF00D, 32'h0,        5'd16, 3,  1'b1, 4'b1111, 32'hCAFEF00D, 32'h0,        1'b0};
        tbl[9]  = '{1'b0, 2'd1, 1'b0, 32'hA001, 32'h0,        32'h0,        5'd17, 0,  1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};
        tbl[10] = '{1'b0, 2'd0, 1'b1, 32'hB002, 32'h0,        32'h00F10000, 5'd18, 0,  1'b1, 4'b0100, 32'h0,        32'h000000F1, 1'b0};
        tbl[11] = '{1'b0, 2'd0, 1'b0, 32'hB000, 32'h0,        32'h0000007F, 5'd19, 0,  1'b1, 4'b0001, 32'h0,        32'h0000007F, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'hC000, 32'h0,        32'h11111111, 5'd20, -1, 1'b1, 4'b1111, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{1'b1, 2'd2, 1'b0, 32'hC001, 32'h1,        32'h0,        5'd21, 0,  1'b0, 4'b0000, 32'h0,        32'h0,        1'b1};

        rst_n = 1'b0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_uns = 1'b0;
        req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'd0; bus_ack = 1'b0; bus_rdata = 32'h0;
        d_valid = 1'b0; d_we = 1'b0; d_size = 2'd0; d_uns = 1'b0;
        d_addr = 32'h0; d_wdata = 64'h0; d_rd = 5'd0; d_ack = 1'b0; d_rdata = 64'h0;
        repeat (3) @(negedge clk);
        chk("reset_ready", req_ready, 1);
        chk("reset_bus_req", bus_req, 0);
        chk("reset_rsp_valid", rsp_valid, 0);
        chk("reset_rsp_err", rsp_err, 0);
        chk("reset_bus_be", bus_be, 0);
        chk("reset_d_ready", d_ready, 1);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) txn(tbl[i]);

        // Timeout followed by late acks that must be ignored.
        txn(tbl[12]);
        bus_ack = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("late_ack_rsp_valid", rsp_valid, 0);
            chk("late_ack_bus_req", bus_req, 0);
        end
        bus_ack = 1'b0;

        back_to_back();

        // Reset asserted while the bus cycle is pending.
        @(negedge clk);
        chk("rst_seq_ready", req_ready, 1);
        req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h200; req_rd = 5'd1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("rst_seq_bus_req_before", bus_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_seq_bus_req_after", bus_req, 0);
        chk("rst_seq_rsp_valid", rsp_valid, 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_seq_ready_release", req_ready, 1);
        repeat (3) begin
            @(negedge clk);
            chk("rst_seq_no_rsp", rsp_valid, 0);
            chk("rst_seq_no_bus", bus_req, 0);
        end

        for (int k = 0; k < 150; k++) begin
            vec_t v;
            v.we = 1'($urandom); v.size = 2'($urandom); v.uns = 1'($urandom);
            v.addr = $urandom; v.wdata = $urandom; v.rdata = $urandom; v.rd = 5'($urandom);
            if ($urandom_range(0, 1) == 1) v.addr[1:0] = 2'b00;
            v.ack_at = int'($urandom_range(0, 5));
            v.bus = 1'b0; v.be = 4'd0; v.bwdata = 32'd0; v.rsp = 32'd0; v.err = 1'b0;
            txn(model(v));
        end

        txn64(1'b0, 2'd3, 1'b0, 32'h8,  64'h0, 64'h8877665544332211, 8'hFF, 64'h0, 64'h8877665544332211);
        txn64(1'b0, 2'd2, 1'b0, 32'h14, 64'h0, 64'h80000000_00000000, 8'hF0, 64'h0, 64'hFFFFFFFF_80000000);
        txn64(1'b0, 2'd2, 1'b1, 32'h14, 64'h0, 64'h80000000_00000000, 8'hF0, 64'h0, 64'h00000000_80000000);
        txn64(1'b1, 2'd2, 1'b0, 32'h10, 64'h12345678_DEADBEEF, 64'h0, 8'h0F, 64'hDEADBEEF_DEADBEEF, 64'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
